// File: rtl/math_expr_pkg.sv
// Shared types and helpers for the math_expression arbiter: controller state
// encoding, width constants and the round-robin grant picker.
package math_expr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Largest supported requester count; the picker works on a vector this wide.
   localparam int N_MAX  = 16;
   // Index width wide enough for N_MAX requesters.
   localparam int ID_W   = 4;
   localparam int WDOG_W = 8;

   // First requester with req set, scanning ptr, ptr+1, ... modulo n.
   // Returns 0 when nothing is requesting; callers qualify with |req.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_MAX-1:0] req,
                                               input logic [ID_W-1:0]  ptr,
                                               input int               n);
      logic [ID_W-1:0] pick;
      logic            found;
      int              idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < N_MAX; k++) begin
         idx = (int'(ptr) + k) % n;
         if (k < n && !found && req[idx]) begin
            pick  = ID_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/math_expression.sv
// Two-stage datapath: q = num >>> 1, rmd = num[0] with
// num = (a-b)*(1+3c) - 4d, all arithmetic modulo 2^W (two's complement).
// valid pulses two cycles after start.
module math_expression #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         rmd,
   output logic         valid
);

   logic [W-1:0] num;
   logic [W-1:0] num_r;
   logic         v1;

   // Truncating W-bit arithmetic gives the two's-complement result directly.
   always_comb begin
      num = (a - b) * ((c << 1) + c + W'(1)) - (d << 2);
   end

   // Stage 1 captures the expression, stage 2 splits it into quotient/remainder.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_r <= '0;
         v1    <= 1'b0;
         q     <= '0;
         rmd   <= 1'b0;
         valid <= 1'b0;
      end else begin
         v1    <= start;
         valid <= v1;
         if (start) num_r <= num;
         if (v1) begin
            q   <= $signed(num_r) >>> 1;
            rmd <= num_r[0];
         end
      end
   end

endmodule

// File: rtl/math_expression_arbiter.sv
// Round-robin front end sharing one math_expression datapath among N
// requesters, one operation in flight, with a watchdog on the datapath.
//
// Handshakes: a request transfers on a cycle where req_valid[i] & req_ready[i];
// req_ready is one-hot, combinational and only non-zero in IDLE. The response
// transfers on rsp_valid & rsp_ready; rsp_* fields hold steady until then.
module math_expression_arbiter
   import math_expr_pkg::*;
#(
   parameter int W       = 16,
   parameter int N       = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req_valid,
   output logic [N-1:0]         req_ready,
   input  logic [N*W-1:0]       req_a,
   input  logic [N*W-1:0]       req_b,
   input  logic [N*W-1:0]       req_c,
   input  logic [N*W-1:0]       req_d,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [$clog2(N)-1:0] rsp_id,
   output logic [W-1:0]         rsp_q,
   output logic                 rsp_rmd,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam int IDW = $clog2(N);

   state_t            state;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    grant;
   logic [IDW-1:0]    next_ptr;
   logic [IDW-1:0]    cur_id;
   logic              any_req;
   logic [W-1:0]      lat_a, lat_b, lat_c, lat_d;
   logic [WDOG_W-1:0] wdog;
   logic              dp_start;
   logic              dp_valid;
   logic [W-1:0]      dp_q;
   logic              dp_rmd;

   assign busy = (state != IDLE);

   // Grant selection and the one-hot accept, offered only while IDLE.
   always_comb begin
      grant     = IDW'(rr_pick(N_MAX'(req_valid), ID_W'(rr_ptr), N));
      next_ptr  = (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;
      any_req   = |req_valid;
      req_ready = '0;
      if (state == IDLE && any_req) req_ready[grant] = 1'b1;
   end

   // Controller: accept, issue a one-cycle start, wait with watchdog, hold response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         lat_a     <= '0;
         lat_b     <= '0;
         lat_c     <= '0;
         lat_d     <= '0;
         wdog      <= '0;
         dp_start  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_q     <= '0;
         rsp_rmd   <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  lat_a    <= req_a[grant*W +: W];
                  lat_b    <= req_b[grant*W +: W];
                  lat_c    <= req_c[grant*W +: W];
                  lat_d    <= req_d[grant*W +: W];
                  cur_id   <= grant;
                  rr_ptr   <= next_ptr;
                  dp_start <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               dp_start <= 1'b0;
               wdog     <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (dp_valid) begin
                  rsp_q     <= dp_q;
                  rsp_rmd   <= dp_rmd;
                  rsp_err   <= 1'b0;
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                  rsp_q     <= '0;
                  rsp_rmd   <= 1'b0;
                  rsp_err   <= 1'b1;
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   math_expression #(.W(W)) u_dp (
      .clk   (clk),
      .reset (reset),
      .start (dp_start),
      .a     (lat_a),
      .b     (lat_b),
      .c     (lat_c),
      .d     (lat_d),
      .q     (dp_q),
      .rmd   (dp_rmd),
      .valid (dp_valid)
   );

endmodule

// File: tb/tb_math_expression_arbiter.sv
// Bench for math_expression_arbiter: directed steps plus randomized operations
// checked against a behavioural model of grant order and arithmetic.
module tb_math_expression_arbiter;
   localparam int W       = 16;
   localparam int N       = 4;
   localparam int TIMEOUT = 15;
   localparam int IDW     = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a, req_b, req_c, req_d;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic [W-1:0]     rsp_q;
   logic             rsp_rmd;
   logic             rsp_err;
   logic             busy;

   int vectors     = 0;
   int miscompares = 0;
   int exp_ptr     = 0;

   logic [W-1:0] op_a[N], op_b[N], op_c[N], op_d[N];
   logic [31:0]  exp_q[$];
   int           last_id;
   logic [W-1:0] last_q;
   logic         last_rmd;
   logic         last_err;

   math_expression_arbiter #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .req_d     (req_d),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_q     (rsp_q),
      .rsp_rmd   (rsp_rmd),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Grant rule: first requester asking, starting at the pointer, wrapping.
   function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
      for (int k = 0; k < N; k++)
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // Expected response packed as {id[31:24], err[17], rmd[16], q[15:0]}.
   function automatic logic [31:0] model_rsp(input int id, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] c,
                                             input logic [W-1:0] d, input bit err);
      longint            num, sn, qv, rv;
      logic signed [15:0] t;
      logic [15:0]        q16;
      if (err) return {8'(id), 6'b0, 1'b1, 1'b0, 16'h0};
      num = (longint'($signed(a)) - longint'($signed(b))) * (1 + 3 * longint'($signed(c)))
            - 4 * longint'($signed(d));
      t   = num[15:0];
      sn  = longint'(t);
      qv  = sn >>> 1;
      rv  = sn & 1;
      q16 = qv[15:0];
      return {8'(id), 6'b0, 1'b0, rv[0], q16};
   endfunction

   task automatic pack_ops();
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
         req_c[i*W +: W] = op_c[i];
         req_d[i*W +: W] = op_d[i];
      end
   endtask

   task automatic randomize_ops();
      for (int i = 0; i < N; i++) begin
         op_a[i] = W'($urandom);
         op_b[i] = W'($urandom);
         op_c[i] = W'($urandom);
         op_d[i] = W'($urandom);
      end
      pack_ops();
   endtask

   task automatic set_op(input int i, input int a, input int b, input int c, input int d);
      op_a[i] = W'(a);
      op_b[i] = W'(b);
      op_c[i] = W'(c);
      op_d[i] = W'(d);
      pack_ops();
   endtask

   // One full operation from an IDLE cycle through response consumption.
   task automatic run_op(input logic [N-1:0] mask, input int rdy_delay, input bit wd);
      int           g, lat;
      bit           got;
      logic [N-1:0] oh;
      logic [31:0]  e;
      req_valid = mask;
      #1;
      g  = model_pick(mask, exp_ptr);
      oh = '0;
      oh[g] = 1'b1;
      chk("req_ready_grant", 32'(req_ready), 32'(oh));
      exp_q.push_back(model_rsp(g, op_a[g], op_b[g], op_c[g], op_d[g], wd));
      exp_ptr = (g + 1) % N;
      if (wd) force dut.dp_valid = 1'b0;
      @(posedge clk);
      #1;
      randomize_ops();
      lat = 0;
      got = 0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) got = 1;
         else chk("req_ready_busy", 32'(req_ready), 32'h0);
      end
      chk("latency", 32'(lat), wd ? 32'(TIMEOUT + 2) : 32'd4);
      e = exp_q.pop_front();
      last_id  = int'(rsp_id);
      last_q   = rsp_q;
      last_rmd = rsp_rmd;
      last_err = rsp_err;
      chk("rsp_id", 32'(rsp_id), 32'(e[31:24]));
      chk("rsp_q", 32'(rsp_q), 32'(e[15:0]));
      chk("rsp_rmd", 32'(rsp_rmd), 32'(e[16]));
      chk("rsp_err", 32'(rsp_err), 32'(e[17]));
      chk("busy_resp", 32'(busy), 32'h1);
      if (wd) begin
         force dut.dp_valid = 1'b1;
         @(negedge clk);
         release dut.dp_valid;
         @(negedge clk);
         chk("stray_valid_q", 32'(rsp_q), 32'(e[15:0]));
         chk("stray_valid_err", 32'(rsp_err), 32'(e[17]));
      end
      for (int i = 0; i < rdy_delay; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'h1);
         chk("hold_q", 32'(rsp_q), 32'(e[15:0]));
         chk("hold_id", 32'(rsp_id), 32'(e[31:24]));
         chk("hold_req_ready", 32'(req_ready), 32'h0);
         chk("hold_no_start", 32'(dut.dp_start), 32'h0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("consumed_valid", 32'(rsp_valid), 32'h0);
      chk("consumed_busy", 32'(busy), 32'h0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_id"}, 32'(rsp_id), 32'h0);
      chk({tag, "_q"}, 32'(rsp_q), 32'h0);
      chk({tag, "_rmd"}, 32'(rsp_rmd), 32'h0);
      chk({tag, "_err"}, 32'(rsp_err), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
   endtask

   // Start an op on requester 2, then reset after cyc cycles; no response may follow.
   task automatic reset_mid(input int cyc, input string tag);
      bit saw;
      randomize_ops();
      req_valid = 4'b0100;
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (cyc) @(negedge clk);
      if (cyc >= 4) chk({tag, "_in_resp"}, 32'(rsp_valid), 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      exp_ptr = 0;
      check_zero(tag);
      saw = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid || busy) saw = 1;
      end
      chk({tag, "_no_rsp"}, 32'(saw), 32'h0);
   endtask

   initial begin
      logic [N-1:0] m;
      int           fair_ids[5];
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      randomize_ops();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_zero("reset");

      // Directed arithmetic on requester 0
      set_op(0, 10, 4, 2, 3);
      run_op(4'b0001, 0, 0);
      chk("dir_q15", 32'(last_q), 32'd15);
      chk("dir_rmd0", 32'(last_rmd), 32'h0);
      chk("dir_id0", 32'(last_id), 32'h0);
      set_op(0, 0, 1, 0, 0);
      run_op(4'b0001, 0, 0);
      chk("neg_q", 32'(last_q), 32'h0000ffff);
      chk("neg_rmd", 32'(last_rmd), 32'h1);
      set_op(0, 3, 0, 0, 0);
      run_op(4'b0001, 0, 0);
      chk("odd_q", 32'(last_q), 32'h1);
      chk("odd_rmd", 32'(last_rmd), 32'h1);

      // Fairness from a freshly reset pointer
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      exp_ptr = 0;
      fair_ids = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         randomize_ops();
         run_op(4'b1111, 0, 0);
         chk("fair_id", 32'(last_id), 32'(fair_ids[i]));
      end
      randomize_ops();
      run_op(4'b1111, 0, 0);
      chk("fair_id_ptr2", 32'(last_id), 32'h1);
      run_op(4'b1010, 0, 0);
      chk("sparse_id3", 32'(last_id), 32'h3);
      run_op(4'b1010, 0, 0);
      chk("sparse_id1", 32'(last_id), 32'h1);

      // Backpressure
      randomize_ops();
      run_op(4'b1111, 10, 0);

      // Watchdog abort, then a normal op
      randomize_ops();
      run_op(4'b1111, 2, 1);
      chk("wd_err", 32'(last_err), 32'h1);
      chk("wd_q0", 32'(last_q), 32'h0);
      randomize_ops();
      run_op(4'b1111, 0, 0);
      chk("after_wd_err", 32'(last_err), 32'h0);

      // Reset while waiting and while holding a response
      req_valid = '0;
      reset_mid(2, "rst_wait");
      randomize_ops();
      run_op(4'b1111, 0, 0);
      chk("ptr0_after_rst_wait", 32'(last_id), 32'h0);
      req_valid = '0;
      reset_mid(4, "rst_resp");
      randomize_ops();
      run_op(4'b1111, 0, 0);
      chk("ptr0_after_rst_resp", 32'(last_id), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 25; i++) begin
         m = N'($urandom_range(1, 15));
         randomize_ops();
         run_op(m, $urandom_range(0, 3), 0);
      end

      req_valid = '0;
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
